dif_radix2_64p_seq: RTL and testbench
=====================================

Name: dif_radix2_64p_seq

Overview:
Frame sequencer for the 64-point radix-2 DIF single-delay-feedback pipeline (6 stages, each with a twiddle multiplier instance).
- Generates the global pipeline freeze (halt_ctrl) and, per stage, the multiplier enable and 6-bit twiddle index W64^k (tm64_ctrl).
- Accepts one 64-sample frame, then flushes the pipeline and flags the 64 output beats.

Parameters:
STAGE_LAT, 1, register latency per stage on top of its delay line; legal 0..15
NPT_LOG2, 6, log2 points; fixed at 6, other values unsupported

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  input sample present this cycle
in_last  in  1  marks the final sample of a frame
in_ready  out  1  sequencer accepts input samples
halt_ctrl  out  1  1 = freeze every pipeline stage this cycle
stage_tm_en  out  6  bit s: stage s multiplier applies twiddle (0 = pass-through, W^0)
stage_tm_ctrl  out  36  bits [6s+5:6s]: stage s twiddle index k
out_valid  out  1  pipeline output sample valid
out_first  out  1  first output beat of the frame
out_last  out  1  last output beat of the frame
out_idx  out  6  index of the current output sample
busy  out  1  state != IDLE
frame_err  out  1  one-cycle pulse on framing error

Behaviour:
- Reset: state IDLE, beat counter b = 0. Outputs: halt_ctrl=1, in_ready=0, and all other outputs 0. A reset asserted mid-frame aborts the frame with no output flagged.
- Beat counter b (8 bits) counts advancing cycles, i.e. cycles with halt_ctrl=0, since frame start.
- Per-stage offsets: D_s = sum over j<s of ((32>>j) + STAGE_LAT). With default STAGE_LAT=1, D = 0,33,50,59,64,67.
- Total latency: L = 63 + 6*STAGE_LAT (default 69).
- States:
  - IDLE: in_ready=1, halt_ctrl=1. A cycle with in_valid=1 is beat 0: go to RUN, halt_ctrl=0 that cycle, b increments.
  - RUN: in_ready=1; halt_ctrl = ~in_valid; b increments only on in_valid. The beat with b=63 moves to FLUSH on the next cycle.
  - FLUSH: in_ready=0; halt_ctrl=0 every cycle; b increments every cycle. in_valid is ignored (upstream must hold the data). After the cycle with b = 63+L, go to IDLE with b=0.
- Stage control, evaluated each cycle from the current b:
  - Stage s is live when D_s <= b < D_s+64. Its local index is n = b - D_s, span = 32>>s, m = n mod (2*span).
  - If live and m >= span: stage_tm_en[s]=1 and ctrl = (m - span) << s.
  - Otherwise: en=0 and ctrl=0.
  - The fields change only when b changes. While halted, all fields hold their values.
- Output window: out_valid=1 when b in [L, L+63], with out_idx = b - L. out_first is set at b=L and out_last at b=L+63.
- Framing: frame length is always 64 accepted beats.
  - in_last on an accepted beat other than 63, or absent on beat 63, gives frame_err=1 for one cycle (the cycle after that beat).
  - The frame still completes normally.
- No frame overlap: the next frame's beat 0 is accepted only in IDLE.
- All outputs are registered, except in_ready and halt_ctrl, which are combinational from state and in_valid.

Optional Feature:
CTRL_BITREV_EN:
- Defined: out_idx = bit-reverse of (b - L), giving the natural-order frequency bin of each DIF output.
- Undefined: out_idx = b - L, i.e. arrival order. No other behaviour changes.

Test Plan:
- Continuous frame (STAGE_LAT=1):
  - in_valid=1 for 64 cycles, in_last on beat 63 -> busy stays high for 133 advancing cycles.
  - out_valid high for b=69..132, out_first at b=69, out_last at b=132, then IDLE.
- Stage twiddles:
  - Stage 0: b=40 -> en[0]=1, ctrl0=8; b=20 -> en[0]=0, ctrl0=0.
  - Stage 1: b=52 -> en[1]=1, ctrl1=6.
  - Stage 5: b=68 -> en[5]=1, ctrl5=0; b=67 -> en[5]=0.
- Gapped input: in_valid low for 5 cycles mid-RUN (after beat 10) -> halt_ctrl=1 for those 5 cycles, all ctrl fields hold, b stays 11, frame_err=0.
- Framing error: in_last asserted on beat 30 -> frame_err pulses once, frame still runs 64 input beats, out_valid count = 64.
- Reset mid-FLUSH: rst at b=100 -> next cycle IDLE, halt_ctrl=1, out_valid=0, ctrl fields 0; a new frame starts cleanly.
- CTRL_BITREV_EN defined: out_idx at b=70 is 32, at b=71 is 16 (undefined: 1 and 2).

Source files
------------

// File: rtl/dif_radix2_64p_seq.sv
// Frame sequencer for the 64-point radix-2 DIF SDF pipeline: global halt, per-stage twiddle control, output framing.
// Optional: define CTRL_BITREV_EN to report out_idx as the bit-reversed (natural-order) frequency bin.
module dif_radix2_64p_seq #(
  parameter int STAGE_LAT = 1,
  parameter int NPT_LOG2  = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic        halt_ctrl,
  output logic [5:0]  stage_tm_en,
  output logic [35:0] stage_tm_ctrl,
  output logic        out_valid,
  output logic        out_first,
  output logic        out_last,
  output logic [5:0]  out_idx,
  output logic        busy,
  output logic        frame_err
);

  localparam int NPT = 1 << NPT_LOG2;
  localparam int LAT = 63 + 6 * STAGE_LAT;
  localparam logic [7:0] LAST_IN_B = 8'(NPT - 1);
  localparam logic [7:0] LAT_B     = 8'(LAT);
  localparam logic [7:0] END_B     = 8'(63 + LAT);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [7:0]  b_r, b_nxt_s;
  logic        accept_s;

  logic [5:0]  stage_en_s;
  logic [35:0] stage_ctrl_s;
  logic        win_s, first_s, last_s, frame_err_s, busy_s;
  logic [5:0]  idx_raw_s, idx_s;

  logic [5:0]  stage_en_r;
  logic [35:0] stage_ctrl_r;
  logic        out_valid_r, out_first_r, out_last_r, busy_r, frame_err_r;
  logic [5:0]  out_idx_r;

  // Beat offset of stage s: sum of the earlier delay lines plus their register latency.
  function automatic int stage_off(input int s);
    int acc;
    acc = 0;
    for (int j = 0; j < s; j++) begin
      acc = acc + (32 >> j) + STAGE_LAT;
    end
    return acc;
  endfunction

  // Returns {enable, twiddle index} for stage s at beat b.
  function automatic logic [6:0] stage_field(input logic [7:0] b, input int s);
    logic [8:0] b9, d9, n9, span9;
    logic [6:0] f;
    b9    = {1'b0, b};
    d9    = 9'(stage_off(s));
    span9 = 9'd32 >> s;
    n9    = b9 - d9;
    f     = 7'd0;
    if ((b9 >= d9) && (b9 < (d9 + 9'd64))) begin
      if ((n9 & span9) != 9'd0) begin
        f = {1'b1, 6'((n9 & (span9 - 9'd1)) << s)};
      end else begin
        f = 7'd0;
      end
    end else begin
      f = 7'd0;
    end
    return f;
  endfunction

`ifdef CTRL_BITREV_EN
  function automatic logic [5:0] bitrev6(input logic [5:0] v);
    return {v[0], v[1], v[2], v[3], v[4], v[5]};
  endfunction
`endif

  // State and beat counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      b_r     <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      b_r     <= b_nxt_s;
    end
  end

  // Next-state and beat-counter logic.
  always_comb begin
    state_nxt_s = state_r;
    b_nxt_s     = b_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_RUN;
          b_nxt_s     = b_r + 8'd1;
        end else begin
          b_nxt_s = 8'd0;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          accept_s = 1'b1;
          b_nxt_s  = b_r + 8'd1;
          if (b_r == LAST_IN_B) begin
            state_nxt_s = ST_FLUSH;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end else begin
          b_nxt_s = b_r;
        end
      end
      ST_FLUSH: begin
        if (b_r == END_B) begin
          state_nxt_s = ST_IDLE;
          b_nxt_s     = 8'd0;
        end else begin
          b_nxt_s = b_r + 8'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        b_nxt_s     = 8'd0;
      end
    endcase
  end

  // Combinational handshake: freeze when no sample arrives, never during flush.
  always_comb begin
    in_ready  = 1'b0;
    halt_ctrl = 1'b1;
    if (rst) begin
      in_ready  = 1'b0;
      halt_ctrl = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE, ST_RUN: begin
          in_ready  = 1'b1;
          halt_ctrl = ~in_valid;
        end
        ST_FLUSH: begin
          in_ready  = 1'b0;
          halt_ctrl = 1'b0;
        end
        default: begin
          in_ready  = 1'b0;
          halt_ctrl = 1'b1;
        end
      endcase
    end
  end

  // Registered-output next values, decoded from the upcoming beat so they stay aligned with b.
  always_comb begin
    logic [6:0] f;
    stage_en_s   = 6'd0;
    stage_ctrl_s = 36'd0;
    f            = 7'd0;
    for (int s = 0; s < 6; s++) begin
      f                    = stage_field(b_nxt_s, s);
      stage_en_s[s]        = f[6];
      stage_ctrl_s[6*s +: 6] = f[5:0];
    end
    win_s       = (b_nxt_s >= LAT_B) && (b_nxt_s <= END_B);
    first_s     = win_s && (b_nxt_s == LAT_B);
    last_s      = win_s && (b_nxt_s == END_B);
    idx_raw_s   = 6'(b_nxt_s - LAT_B);
`ifdef CTRL_BITREV_EN
    idx_s       = win_s ? bitrev6(idx_raw_s) : 6'd0;
`else
    idx_s       = win_s ? idx_raw_s : 6'd0;
`endif
    frame_err_s = accept_s && (in_last != (b_r == LAST_IN_B));
    busy_s      = (state_nxt_s != ST_IDLE);
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_en_r   <= 6'd0;
      stage_ctrl_r <= 36'd0;
      out_valid_r  <= 1'b0;
      out_first_r  <= 1'b0;
      out_last_r   <= 1'b0;
      out_idx_r    <= 6'd0;
      busy_r       <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      stage_en_r   <= stage_en_s;
      stage_ctrl_r <= stage_ctrl_s;
      out_valid_r  <= win_s;
      out_first_r  <= first_s;
      out_last_r   <= last_s;
      out_idx_r    <= idx_s;
      busy_r       <= busy_s;
      frame_err_r  <= frame_err_s;
    end
  end

  assign stage_tm_en   = stage_en_r;
  assign stage_tm_ctrl = stage_ctrl_r;
  assign out_valid     = out_valid_r;
  assign out_first     = out_first_r;
  assign out_last      = out_last_r;
  assign out_idx       = out_idx_r;
  assign busy          = busy_r;
  assign frame_err     = frame_err_r;

endmodule

// File: tb/tb_dif_radix2_64p_seq.sv
// Self-checking bench for dif_radix2_64p_seq: per-cycle reference model, output-index scoreboard and vector tables.
module tb_dif_radix2_64p_seq;

  localparam int SL = 1;
  localparam int L  = 63 + 6 * SL;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_last;
  logic        in_ready, halt_ctrl, out_valid, out_first, out_last, busy, frame_err;
  logic [5:0]  stage_tm_en, out_idx;
  logic [35:0] stage_tm_ctrl;

  int n_cmp = 0;
  int n_bad = 0;
  int sb[$];

  typedef struct { int b; int s; int en; int ctrl; } stage_vec_t;
  typedef struct { int b; int idx; } idx_vec_t;
  stage_vec_t svec[6];
  idx_vec_t   ivec[2];

  dif_radix2_64p_seq #(.STAGE_LAT(SL), .NPT_LOG2(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .halt_ctrl(halt_ctrl), .stage_tm_en(stage_tm_en), .stage_tm_ctrl(stage_tm_ctrl),
    .out_valid(out_valid), .out_first(out_first), .out_last(out_last), .out_idx(out_idx),
    .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int d_of(input int s);
    int d = 0;
    for (int j = 0; j < s; j++) d += (32 >> j) + SL;
    return d;
  endfunction

  function automatic void exp_stage(input int b, input int s, output int en, output int ctrl);
    int d, n, span, m;
    d = d_of(s); en = 0; ctrl = 0;
    if (b >= d && b < d + 64) begin
      n = b - d; span = 32 >> s; m = n % (2 * span);
      if (m >= span) begin en = 1; ctrl = (m - span) * (1 << s); end
    end
  endfunction

  function automatic int exp_idx(input int e);
    int r = 0;
`ifdef CTRL_BITREV_EN
    for (int k = 0; k < 6; k++) if ((e >> k) & 1) r += 32 >> k;
`else
    r = e;
`endif
    return r;
  endfunction

  task automatic check_model(input int b, input int busy_exp, input int err_exp, input bit use_tbl,
                             inout int outs, inout int errs);
    int en, ctrl, ev, e;
    for (int s = 0; s < 6; s++) begin
      exp_stage(b, s, en, ctrl);
      chk($sformatf("en[%0d]@b%0d", s, b), int'(stage_tm_en[s]), en);
      chk($sformatf("ctrl[%0d]@b%0d", s, b), int'(stage_tm_ctrl[6*s +: 6]), ctrl);
    end
    ev = (b >= L && b <= L + 63) ? 1 : 0;
    chk($sformatf("out_valid@b%0d", b), int'(out_valid), ev);
    chk($sformatf("busy@b%0d", b), int'(busy), busy_exp);
    chk($sformatf("frame_err@b%0d", b), int'(frame_err), err_exp);
    if (frame_err) errs++;
    if (ev == 1) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = sb.pop_front();
        chk($sformatf("out_idx@b%0d", b), int'(out_idx), exp_idx(e));
        chk($sformatf("out_first@b%0d", b), int'(out_first), (e == 0) ? 1 : 0);
        chk($sformatf("out_last@b%0d", b), int'(out_last), (e == 63) ? 1 : 0);
      end
    end
    if (out_valid) outs++;
    if (use_tbl) begin
      for (int i = 0; i < 6; i++) begin
        if (svec[i].b == b) begin
          chk($sformatf("tbl_en s%0d b%0d", svec[i].s, b), int'(stage_tm_en[svec[i].s]), svec[i].en);
          chk($sformatf("tbl_ctrl s%0d b%0d", svec[i].s, b), int'(stage_tm_ctrl[6*svec[i].s +: 6]), svec[i].ctrl);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (ivec[i].b == b) chk($sformatf("tbl_idx b%0d", b), int'(out_idx), ivec[i].idx);
      end
    end
  endtask

  // One frame from IDLE; gap_beat<0 disables the gap, rst_b<0 disables the mid-flush reset.
  task automatic run_frame(input int gap_beat, input int gap_len, input int extra_last,
                           input int rst_b, input bit use_tbl);
    int tb_b = 0, beat = 0, gap_left, cyc = 0, outs = 0, errs = 0, errs_exp = 0, err_next;
    bit flushing = 0, done = 0, valid, last, rst_now;
    gap_left = gap_len;
    while (!done && cyc < 400) begin
      cyc++;
      if (!flushing && beat == gap_beat && gap_left > 0) begin
        valid = 0; gap_left--;
      end else begin
        valid = !flushing;
      end
      last    = valid && (beat == 63 || beat == extra_last);
      rst_now = (rst_b >= 0) && flushing && (tb_b == rst_b);
      in_valid = valid; in_last = last; rst = rst_now;
      #1;
      chk("halt_ctrl", int'(halt_ctrl), rst_now ? 1 : (flushing ? 0 : (valid ? 0 : 1)));
      chk("in_ready", int'(in_ready), (rst_now || flushing) ? 0 : 1);
      err_next = 0;
      if (valid) begin
        sb.push_back(beat);
        err_next = (last != (beat == 63)) ? 1 : 0;
        errs_exp += err_next;
        beat++;
      end
      @(posedge clk);
      if (rst_now) begin
        done = 1;
      end else if (flushing) begin
        if (tb_b == 63 + L) begin done = 1; tb_b = 0; end else tb_b++;
      end else if (valid) begin
        tb_b++;
        if (beat == 64) flushing = 1;
      end
      @(negedge clk);
      in_valid = 0; in_last = 0; rst = 0;
      if (rst_now) begin
        #1;
        chk("rst_halt", int'(halt_ctrl), 1);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_en", int'(stage_tm_en), 0);
        chk("rst_ctrl_zero", (stage_tm_ctrl == 36'd0) ? 1 : 0, 1);
        sb.delete();
      end else begin
        check_model(tb_b, done ? 0 : 1, err_next, use_tbl, outs, errs);
      end
    end
    if (!done) chk("frame_timeout", 0, 1);
    if (rst_b < 0) begin
      chk("out_count", outs, 64);
      chk("err_pulses", errs, errs_exp);
      chk("sb_empty", sb.size(), 0);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      chk("idle_halt", int'(halt_ctrl), 1);
      chk("idle_busy", int'(busy), 0);
      chk("idle_out_valid", int'(out_valid), 0);
    end
  endtask

  initial begin
    svec[0] = '{b: 40, s: 0, en: 1, ctrl: 8};
    svec[1] = '{b: 20, s: 0, en: 0, ctrl: 0};
    svec[2] = '{b: 52, s: 1, en: 1, ctrl: 6};
    svec[3] = '{b: 68, s: 5, en: 1, ctrl: 0};
    svec[4] = '{b: 67, s: 5, en: 0, ctrl: 0};
    svec[5] = '{b: 60, s: 2, en: 1, ctrl: 8};
`ifdef CTRL_BITREV_EN
    ivec[0] = '{b: 70, idx: 32};
    ivec[1] = '{b: 71, idx: 16};
`else
    ivec[0] = '{b: 70, idx: 1};
    ivec[1] = '{b: 71, idx: 2};
`endif

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    repeat (3) @(negedge clk);
    in_valid = 1'b1;
    #1;
    chk("reset_halt", int'(halt_ctrl), 1);
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_en", int'(stage_tm_en), 0);
    chk("reset_ctrl_zero", (stage_tm_ctrl == 36'd0) ? 1 : 0, 1);
    chk("reset_frame_err", int'(frame_err), 0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_reset_in_ready", int'(in_ready), 1);
    chk("post_reset_halt", int'(halt_ctrl), 1);

    run_frame(-1, 0, -1, -1, 1'b1);
    idle_cycles(2);
    run_frame(11, 5, -1, -1, 1'b0);
    idle_cycles(1);
    run_frame(-1, 0, 30, -1, 1'b0);
    idle_cycles(1);
    run_frame(-1, 0, -1, 100, 1'b0);
    idle_cycles(2);
    run_frame(-1, 0, -1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
